softex_tcdm_responder: RTL

- Synthesizable TCDM target model: the responder end of the HCI core protocol that the SoftEx streamer drives as initiator.
- Accepts read and write requests from the streamer's tcdm port and services them from an internal word-wide memory.
- Read responses return after a fixed latency, with optional grant stalls and r_ready backpressure.
- Used in SoftEx standalone testbenches and FPGA smoke builds in place of the cluster TCDM and interconnect.

---
 rtl/softex_tcdm_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/softex_tcdm_responder.sv
// ============================================================================
// Module   : softex_tcdm_responder
// Purpose  : TCDM target model for the SoftEx streamer: word-wide memory with
//            fixed-latency in-order read responses, credit-limited grants and
//            optional pseudo-random grant stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module softex_tcdm_responder #(
    parameter int          DATA_WIDTH = 128,
    parameter int          ADDR_WIDTH = 32,
    parameter int          MEM_WORDS  = 1024,
    parameter int          LATENCY    = 1,
    parameter int          FIFO_DEPTH = 4,
    parameter int          STALL_EN   = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic                    err_o,
    output logic [31:0]             n_reads_o,
    output logic [31:0]             n_writes_o
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_OFF   = $clog2(c_BYTES);
    localparam int c_IDX   = $clog2(MEM_WORDS);
    localparam int c_PW    = $clog2(FIFO_DEPTH);
    localparam int c_CW    = $clog2(FIFO_DEPTH + 1);

    logic [15:0]           r_lfsr;
    logic                  w_stall;
    logic                  w_acc;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_oor;
    logic                  w_pop;
    logic                  w_push;
    logic [c_IDX-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [DATA_WIDTH-1:0] r_mem  [MEM_WORDS];
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [c_PW-1:0]       r_wptr;
    logic [c_PW-1:0]       r_rptr;
    logic [c_CW-1:0]       r_fcnt;
    logic [c_CW-1:0]       r_credits;
    logic                  r_err;
    logic [31:0]           r_nrd;
    logic [31:0]           r_nwr;

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(FIFO_DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    assign w_stall  = (STALL_EN != 0) && (r_lfsr[1:0] == 2'b00);
    // Credits cover pipeline stages plus FIFO entries, so grant never overruns the FIFO
    assign gnt_o    = !rst_i && !w_stall && (r_credits < c_CW'(FIFO_DEPTH));
    assign w_acc    = req_i && gnt_o;
    assign w_rd_acc = w_acc && wen_i;
    assign w_wr_acc = w_acc && !wen_i;
    assign w_idx    = add_i[c_OFF +: c_IDX];
    assign w_oor    = |(add_i >> (c_OFF + c_IDX));
    assign w_mem_rdata = r_mem[w_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            for (int k = 0; k < c_BYTES; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_push      = w_rd_acc;
            assign w_push_data = w_mem_rdata;
        end else begin : g_pipe
            logic [LATENCY-2:0]    r_pv;
            logic [DATA_WIDTH-1:0] r_pd [LATENCY-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_rd_acc;
                    r_pd[0] <= w_mem_rdata;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        r_pv[s] <= r_pv[s-1];
                        r_pd[s] <= r_pd[s-1];
                    end
                end
            end

            assign w_push      = r_pv[LATENCY-2];
            assign w_push_data = r_pd[LATENCY-2];
        end
    endgenerate

    assign r_valid_o = (r_fcnt != '0);
    assign r_data_o  = r_valid_o ? r_fifo[r_rptr] : '0;
    assign w_pop     = r_valid_o && r_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fcnt    <= '0;
            r_credits <= '0;
            r_err     <= 1'b0;
            r_nrd     <= '0;
            r_nwr     <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + c_CW'(1);
                2'b01:   r_fcnt <= r_fcnt - c_CW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            case ({w_rd_acc, w_pop})
                2'b10:   r_credits <= r_credits + c_CW'(1);
                2'b01:   r_credits <= r_credits - c_CW'(1);
                default: r_credits <= r_credits;
            endcase
            if (w_acc && w_oor) begin
                r_err <= 1'b1;
            end
            if (w_rd_acc) begin
                r_nrd <= r_nrd + 32'd1;
            end
            if (w_wr_acc) begin
                r_nwr <= r_nwr + 32'd1;
            end
        end
    end

    assign err_o      = r_err;
    assign n_reads_o  = r_nrd;
    assign n_writes_o = r_nwr;

endmodule

`default_nettype wire
